fb_layer_sequencer: RTL and testbench
=====================================

# fb_layer_sequencer

Parametrised write-path sequencer between N drawing sources and the frame manager's write port. On each `frame` pulse it grants the write port to sources one at a time in layer order: source 0 (background) first, then 1, 2, and so on. This gives painter's-order compositing. It muxes the granted source's write bus onto the frame-buffer port and routes `write_awaited` back to that source only. It adds three behaviours over a static `write_source_sel` scheme: a configurable source count, optional skipping of idle sources, and per-source timeout and frame-overrun detection.

## Interface
- `NUM_SOURCES`, 4: number of write sources, ≥2. Index is the layer order; 0 is bottom.
- `COLOR_DEPTH`, 9: colour word width.
- `COORD_W`, 32: x/y address width.
- `SKIP_IDLE`, 1: 1 skips sources whose request was low at the frame pulse; 0 grants every source every frame.
- `TIMEOUT_CYCLES`, 400000: maximum number of grant cycles per source before a forced advance. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- `clk`  in  1  — pixel-domain clock (25 MHz).
- `rst`  in  1  — asynchronous, active-high reset.
- `frame`  in  1  — one-cycle start-of-frame pulse.
- `src_req`  in  NUM_SOURCES  — per-source "has content this frame"; sampled on `frame`.
- `src_color`  in  NUM_SOURCES*COLOR_DEPTH  — packed, source i at `[i*COLOR_DEPTH +: COLOR_DEPTH]`.
- `src_x`, `src_y`  in  NUM_SOURCES*COORD_W  — packed write addresses.
- `src_transparent`, `src_active`, `src_done`  in  NUM_SOURCES  — per-source transparent flag, write-valid, and end-of-layer pulse.
- `src_grant`  out  NUM_SOURCES  — one-hot grant; all zero when no source is granted.
- `src_awaited`  out  NUM_SOURCES  — `fb_awaited` routed to the granted source.
- `fb_color`  out  COLOR_DEPTH  — muxed write colour to the frame manager.
- `fb_x`, `fb_y`  out  COORD_W  — muxed write address.
- `fb_transparent`, `fb_active`  out  1  — muxed transparent flag and write-valid.
- `fb_awaited`  in  1  — frame manager accepts the write this cycle.
- `fb_source_sel`  out  SEL_W  — index of the granted source.
- `busy`  out  1  — a sequence is in progress.
- `overrun`  out  1  — one-cycle pulse: `frame` arrived while `busy`.
- `timeout_err`  out  NUM_SOURCES  — sticky per-source timeout flags; cleared only by `rst`.

## Operation
States: IDLE, SCAN, GRANT, GAP.
- **IDLE**
  - On `frame`, latch `pend = SKIP_IDLE ? src_req : '1`, then go to SCAN.
- **SCAN**
  - If `pend == 0`, go to IDLE.
  - Otherwise set `cur` = lowest set bit of `pend`, clear that bit, clear the timer, and go to GRANT.
- **GRANT**
  - `src_grant[cur]=1`.
  - `fb_*` = source `cur` bus; `fb_active = src_active[cur]`.
  - `src_awaited[cur] = fb_awaited`.
  - The timer increments every cycle.
  - `src_done[cur]` → GAP.
  - Timer reaching `TIMEOUT_CYCLES-1` without done → set `timeout_err[cur]`, then GAP.
- **GAP**
  - One cycle with grant and `fb_active` low, so no write straddles a source switch. Then go to SCAN.
- **Outside GRANT**
  - `fb_active=0`, `src_grant=0`, `src_awaited=0`.
  - `fb_color/x/y/transparent` hold source-0 values; they are don't-care for the frame manager.
- **`frame` while busy (SCAN/GRANT/GAP)**
  - Pulse `overrun`.
  - Abandon the current sequence and reload `pend` as on a fresh frame.
  - Go to SCAN next cycle. The new frame always wins.
- **`src_done` edge cases**
  - `src_done` from a non-granted source is ignored.
  - `src_done` in the same cycle as a timeout counts as done; `timeout_err` is not set.
- **`busy`** = (state != IDLE).
- **Reset values**
  - State IDLE; `pend`, `cur`, timer, `src_grant`, `src_awaited` = 0.
  - `fb_active=0`, `fb_source_sel=0`, `busy=0`, `overrun=0`, `timeout_err=0`.

## Timing
- `frame` at cycle 0 → SCAN at cycle 1 → first grant visible at cycle 2 (registered state, combinational mux from `cur`).
- Mux path `src_*` → `fb_*` is combinational: zero latency. `fb_awaited` → `src_awaited` is also combinational.
- `src_done` at cycle t → GAP at t+1 → SCAN at t+2 → next grant at t+3. Minimum layer switch cost: 3 cycles.
- Timeout fires on the `TIMEOUT_CYCLES`-th GRANT cycle of a source.
- `overrun` is asserted in the same cycle as the offending `frame` (registered, visible the cycle after).
- `rst` takes effect immediately and asynchronously; all outputs go to reset values, even mid-GRANT.

## Structure
- Shared package `fb_pkg`:
  - `SEL_W = $clog2(NUM_SOURCES)` helper function.
  - `seq_state_t` enum (IDLE, SCAN, GRANT, GAP).
  - Packed-bus slice helper constants.
- One sub-module, `lsb_first_encoder`: parametrised lowest-set-bit finder returning index and valid. It is reused by SCAN.

## Test plan
- **All sources, SKIP_IDLE=1:** NUM_SOURCES=4, `src_req=4'b1111`, each source asserts done after 10 active writes → grants 0,1,2,3 in order; each switch is exactly 3 cycles; `busy` drops after source 3; `fb_x/y/color` match the granted source every accepted write.
- **Skip idle:** `src_req=4'b1010` → only sources 1 and 3 are granted; source 0 and 2 `src_grant` never assert. Same stimulus with SKIP_IDLE=0 → all four are granted.
- **Timeout:** TIMEOUT_CYCLES=16, source 2 never asserts done → grant lasts 16 cycles; `timeout_err=4'b0100` stays sticky; source 3 is still granted afterwards.
- **Overrun:** `frame` during source 1 grant → `overrun` pulses once; next grant is source 0 of the new mask.
- **Backpressure and stray done:** `fb_awaited` low for 5 cycles → the source sees `src_awaited=0` and holds its bus; a `src_done` from a non-granted source causes no state change.
- **Async reset mid-GRANT:** assert `rst` mid-GRANT → all outputs return to reset values in the same cycle; a `frame` after deassert restarts from source 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer write-path blocks.
//   seq_state_t / ST_*  : layer sequencer FSM encoding
//   sel_w()             : width of a source index for a given source count
//   slice_lo()          : low bit of element idx in a packed per-source bus
package fb_pkg;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_SCAN  = 2'd1;
    localparam seq_state_t ST_GRANT = 2'd2;
    localparam seq_state_t ST_GAP   = 2'd3;

    localparam int DEF_NUM_SOURCES = 4;
    localparam int DEF_COLOR_DEPTH = 9;
    localparam int DEF_COORD_W     = 32;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/lsb_first_encoder.sv
// Lowest-set-bit finder.
//   vec   : input bit vector
//   idx   : index of the lowest set bit (0 when none set)
//   valid : at least one bit of vec is set
module lsb_first_encoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last to assign.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_layer_sequencer.sv
// Painter's-order write-port sequencer: on each frame pulse, grants the frame
// manager write port to sources 0..NUM_SOURCES-1 in turn, muxing the granted
// source's bus onto fb_* and routing fb_awaited back to it.
//   clk, rst                 : clock, async active-high reset
//   frame                    : start-of-frame pulse
//   src_req                  : per-source "has content", sampled on frame
//   src_color/x/y            : packed per-source write buses
//   src_transparent/active   : per-source transparent flag and write-valid
//   src_done                 : per-source end-of-layer pulse
//   src_grant, src_awaited   : one-hot grant and routed accept
//   fb_color/x/y/transparent : muxed write bus
//   fb_active, fb_awaited    : muxed write-valid, frame manager accept
//   fb_source_sel            : index of granted source
//   busy, overrun            : sequence running, frame arrived while busy
//   timeout_err              : sticky per-source timeout flags
module fb_layer_sequencer
    import fb_pkg::*;
#(
    parameter int NUM_SOURCES    = 4,
    parameter int COLOR_DEPTH    = 9,
    parameter int COORD_W        = 32,
    parameter int SKIP_IDLE      = 1,
    parameter int TIMEOUT_CYCLES = 400000,
    localparam int SEL_W         = sel_w(NUM_SOURCES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame,
    input  logic [NUM_SOURCES-1:0]         src_req,
    input  logic [NUM_SOURCES*COLOR_DEPTH-1:0] src_color,
    input  logic [NUM_SOURCES*COORD_W-1:0] src_x,
    input  logic [NUM_SOURCES*COORD_W-1:0] src_y,
    input  logic [NUM_SOURCES-1:0]         src_transparent,
    input  logic [NUM_SOURCES-1:0]         src_active,
    input  logic [NUM_SOURCES-1:0]         src_done,
    output logic [NUM_SOURCES-1:0]         src_grant,
    output logic [NUM_SOURCES-1:0]         src_awaited,
    output logic [COLOR_DEPTH-1:0]         fb_color,
    output logic [COORD_W-1:0]             fb_x,
    output logic [COORD_W-1:0]             fb_y,
    output logic                           fb_transparent,
    output logic                           fb_active,
    input  logic                           fb_awaited,
    output logic [SEL_W-1:0]               fb_source_sel,
    output logic                           busy,
    output logic                           overrun,
    output logic [NUM_SOURCES-1:0]         timeout_err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    seq_state_t             state;
    logic [NUM_SOURCES-1:0] pend;
    logic [SEL_W-1:0]       cur;
    logic [TMR_W-1:0]       timer;
    logic [NUM_SOURCES-1:0] frame_mask;
    logic [SEL_W-1:0]       enc_idx;
    logic                   enc_valid;
    logic                   granted;
    logic [SEL_W-1:0]       mux_idx;

    assign frame_mask = (SKIP_IDLE != 0) ? src_req : '1;

    lsb_first_encoder #(
        .WIDTH (NUM_SOURCES),
        .IDX_W (SEL_W)
    ) u_scan_enc (
        .vec   (pend),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pend        <= '0;
            cur         <= '0;
            timer       <= '0;
            overrun     <= 1'b0;
            timeout_err <= '0;
        end else begin
            overrun <= frame && (state != ST_IDLE);
            // A new frame always restarts the sequence, whatever state we are in.
            if (frame) begin
                pend  <= frame_mask;
                state <= ST_SCAN;
            end else begin
                case (state)
                    ST_SCAN: begin
                        if (enc_valid) begin
                            cur           <= enc_idx;
                            pend[enc_idx] <= 1'b0;
                            timer         <= '0;
                            state         <= ST_GRANT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_GRANT: begin
                        timer <= timer + TMR_W'(1);
                        // done wins over a coincident timeout
                        if (src_done[cur]) begin
                            state <= ST_GAP;
                        end else if (timer == TMR_LAST) begin
                            timeout_err[cur] <= 1'b1;
                            state            <= ST_GAP;
                        end
                    end
                    ST_GAP:  state <= ST_SCAN;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        granted   = (state == ST_GRANT);
        // Outside GRANT the data mux parks on source 0.
        mux_idx   = granted ? cur : '0;
        src_grant = '0;
        if (granted) begin
            src_grant[cur] = 1'b1;
        end
        src_awaited    = src_grant & {NUM_SOURCES{fb_awaited}};
        fb_color       = src_color[slice_lo(int'(mux_idx), COLOR_DEPTH) +: COLOR_DEPTH];
        fb_x           = src_x[slice_lo(int'(mux_idx), COORD_W) +: COORD_W];
        fb_y           = src_y[slice_lo(int'(mux_idx), COORD_W) +: COORD_W];
        fb_transparent = src_transparent[mux_idx];
        fb_active      = granted & src_active[mux_idx];
        fb_source_sel  = mux_idx;
        busy           = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_fb_layer_sequencer.sv
module tb_fb_layer_sequencer;

    localparam int N  = 4;
    localparam int CD = 9;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame = 1'b0;
    logic          fb_awaited = 1'b1;
    logic [N-1:0]  src_req = '0;
    logic [N-1:0]  src_transparent = 4'b0101;
    logic [N-1:0]  src_active = '1;
    logic [N-1:0]  src_done = '0;
    logic [N*CD-1:0] src_color;
    logic [N*CW-1:0] src_x;
    logic [N*CW-1:0] src_y;

    logic [N-1:0]  src_grant, src_awaited, timeout_err;
    logic [CD-1:0] fb_color;
    logic [CW-1:0] fb_x, fb_y;
    logic          fb_transparent, fb_active, busy, overrun;
    logic [1:0]    fb_source_sel;

    logic [N-1:0]  grant2, awaited2, timeout_err2;
    logic [CD-1:0] color2;
    logic [CW-1:0] x2, y2;
    logic          transparent2, active2, busy2, overrun2;
    logic [1:0]    sel2;

    logic          seen_clr = 1'b0;
    logic [N-1:0]  seen1, seen2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fb_layer_sequencer #(
        .NUM_SOURCES(N), .COLOR_DEPTH(CD), .COORD_W(CW), .SKIP_IDLE(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .frame(frame), .src_req(src_req), .src_color(src_color),
        .src_x(src_x), .src_y(src_y), .src_transparent(src_transparent),
        .src_active(src_active), .src_done(src_done), .src_grant(src_grant),
        .src_awaited(src_awaited), .fb_color(fb_color), .fb_x(fb_x), .fb_y(fb_y),
        .fb_transparent(fb_transparent), .fb_active(fb_active), .fb_awaited(fb_awaited),
        .fb_source_sel(fb_source_sel), .busy(busy), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    // Same stimulus, but every source is granted regardless of src_req.
    fb_layer_sequencer #(
        .NUM_SOURCES(N), .COLOR_DEPTH(CD), .COORD_W(CW), .SKIP_IDLE(0), .TIMEOUT_CYCLES(16)
    ) dut_all (
        .clk(clk), .rst(rst), .frame(frame), .src_req(src_req), .src_color(src_color),
        .src_x(src_x), .src_y(src_y), .src_transparent(src_transparent),
        .src_active(src_active), .src_done(src_done), .src_grant(grant2),
        .src_awaited(awaited2), .fb_color(color2), .fb_x(x2), .fb_y(y2),
        .fb_transparent(transparent2), .fb_active(active2), .fb_awaited(fb_awaited),
        .fb_source_sel(sel2), .busy(busy2), .overrun(overrun2),
        .timeout_err(timeout_err2)
    );

    always @(posedge clk) begin
        if (seen_clr) begin
            seen1 <= '0;
            seen2 <= '0;
        end else begin
            seen1 <= seen1 | src_grant;
            seen2 <= seen2 | grant2;
        end
    end

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] one;
        one = 1;
        return one << idx;
    endfunction

    function automatic logic [CW-1:0] exp_x(input int idx);
        return CW'(1000 + idx);
    endfunction

    function automatic logic [CW-1:0] exp_y(input int idx);
        return CW'(2000 + idx);
    endfunction

    function automatic logic [CD-1:0] exp_color(input int idx);
        return CD'(9'h140 + idx);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the falling edge.
    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic frame_pulse(input logic [N-1:0] mask);
        src_req = mask;
        frame   = 1'b1;
        cycle();
        frame = 1'b0;
    endtask

    // Advances until a grant appears; exp_n < 0 skips the latency check.
    task automatic wait_grant(input int idx, input int exp_n);
        int n;
        n = 0;
        do begin
            cycle();
            src_done = '0;
            n++;
        end while (src_grant == '0 && n < 40);
        check_eq($sformatf("grant_src%0d", idx), src_grant, onehot(idx));
        if (exp_n >= 0) check_eq($sformatf("grant_latency_src%0d", idx), n, exp_n);
    endtask

    // Serves `writes` accepted cycles, raising done on the last one.
    task automatic serve(input int idx, input int writes);
        for (int w = 0; w < writes; w++) begin
            check_eq("fb_x", fb_x, exp_x(idx));
            check_eq("src_awaited", src_awaited, onehot(idx));
            if (w == 0) begin
                check_eq("fb_y", fb_y, exp_y(idx));
                check_eq("fb_color", fb_color, exp_color(idx));
                check_eq("fb_transparent", fb_transparent, src_transparent[idx]);
                check_eq("fb_source_sel", fb_source_sel, idx);
                check_eq("fb_active", fb_active, 1'b1);
            end
            if (w == writes - 1) src_done = onehot(idx);
            else cycle();
        end
    endtask

    task automatic wait_idle(input int exp_n);
        int n;
        n = 0;
        do begin
            cycle();
            src_done = '0;
            n++;
        end while (busy && n < 40);
        check_eq("busy_drop", busy, 1'b0);
        check_eq("busy_drop_latency", n, exp_n);
    endtask

    initial begin
        int len;
        for (int i = 0; i < N; i++) begin
            src_color[i*CD +: CD] = exp_color(i);
            src_x[i*CW +: CW]     = exp_x(i);
            src_y[i*CW +: CW]     = exp_y(i);
        end

        // Reset values
        #2 rst = 1'b1;
        #1;
        check_eq("rst_grant", src_grant, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_timeout_err", timeout_err, 0);
        check_eq("rst_sel", fb_source_sel, 0);
        check_eq("rst_fb_active", fb_active, 0);
        check_eq("rst_fb_x_src0", fb_x, exp_x(0));
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // All sources in order, 10 writes each
        frame_pulse(4'b1111);
        check_eq("scan_busy", busy, 1'b1);
        check_eq("scan_no_grant", src_grant, 0);
        wait_grant(0, 1);
        serve(0, 10);
        for (int i = 1; i < N; i++) begin
            wait_grant(i, 3);
            serve(i, 10);
        end
        wait_idle(3);
        check_eq("idle_fb_active", fb_active, 0);

        // Skip idle sources
        seen_clr = 1'b1;
        cycle();
        seen_clr = 1'b0;
        frame_pulse(4'b1010);
        wait_grant(1, 1);
        serve(1, 4);
        wait_grant(3, 3);
        serve(3, 4);
        wait_idle(3);
        check_eq("skip_seen", seen1, 4'b1010);
        len = 0;
        while (busy2 && len < 300) begin
            cycle();
            len++;
        end
        check_eq("noskip_idle", busy2, 1'b0);
        check_eq("noskip_seen", seen2, 4'b1111);
        check_eq("no_timeout_yet", timeout_err, 0);

        // Timeout on source 2; source 0 finishes exactly on its 16th cycle
        frame_pulse(4'b1111);
        wait_grant(0, 1);
        serve(0, 16);
        wait_grant(1, 3);
        serve(1, 4);
        wait_grant(2, 3);
        len = 0;
        while (src_grant == 4'b0100 && len < 40) begin
            len++;
            cycle();
        end
        check_eq("timeout_len", len, 16);
        check_eq("timeout_err", timeout_err, 4'b0100);
        wait_grant(3, 2);
        serve(3, 4);
        wait_idle(3);
        check_eq("timeout_sticky", timeout_err, 4'b0100);

        // Overrun during source 1
        frame_pulse(4'b1111);
        wait_grant(0, 1);
        serve(0, 4);
        wait_grant(1, 3);
        check_eq("overrun_before", overrun, 0);
        frame = 1'b1;
        cycle();
        frame = 1'b0;
        check_eq("overrun_pulse", overrun, 1'b1);
        check_eq("overrun_no_grant", src_grant, 0);
        check_eq("overrun_busy", busy, 1'b1);
        cycle();
        check_eq("overrun_once", overrun, 0);
        check_eq("overrun_restart_src0", src_grant, onehot(0));
        serve(0, 2);
        for (int i = 1; i < N; i++) begin
            wait_grant(i, 3);
            serve(i, 2);
        end
        wait_idle(3);

        // Backpressure and stray done
        frame_pulse(4'b0011);
        wait_grant(0, 1);
        fb_awaited = 1'b0;
        src_done   = 4'b0010;
        #1;
        check_eq("bp_awaited_low", src_awaited, 0);
        check_eq("bp_fb_active", fb_active, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            src_done = '0;
            check_eq("bp_hold_grant", src_grant, onehot(0));
            check_eq("bp_hold_x", fb_x, exp_x(0));
        end
        fb_awaited = 1'b1;
        #1;
        check_eq("bp_awaited_restore", src_awaited, onehot(0));
        serve(0, 3);
        wait_grant(1, 3);

        // Async reset mid-GRANT
        rst = 1'b1;
        #1;
        check_eq("arst_grant", src_grant, 0);
        check_eq("arst_awaited", src_awaited, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_fb_active", fb_active, 0);
        check_eq("arst_sel", fb_source_sel, 0);
        check_eq("arst_timeout_err", timeout_err, 0);
        cycle();
        rst = 1'b0;
        cycle();
        check_eq("arst_still_idle", busy, 0);
        frame_pulse(4'b1111);
        wait_grant(0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
